regfile_port_arbiter: RTL

//  Shares one single-ported register file between the decode stage's two read

---
 rtl/regfile_port_arbiter_if.sv | 40 ++++
 rtl/regfile_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle between the decode/writeback requesters, the arbiter and the
// single-ported register file. master = requester/RF side, slave = arbiter.
interface regfile_port_arbiter_if #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic [REG_ADDR_LEN-1:0] src1_addr;
  logic                    src1_en;
  logic [WIDTH-1:0]        src1_data;
  logic                    src1_st;
  logic [REG_ADDR_LEN-1:0] src2_addr;
  logic                    src2_en;
  logic [WIDTH-1:0]        src2_data;
  logic                    src2_st;
  logic [REG_ADDR_LEN-1:0] wb_addr;
  logic [WIDTH-1:0]        wb_data;
  logic                    wb_en;
  logic                    wb_ack;
  logic [REG_ADDR_LEN-1:0] rf_addr;
  logic [WIDTH-1:0]        rf_wdata;
  logic                    rf_we;
  logic                    rf_re;
  logic [WIDTH-1:0]        rf_rdata;
  logic                    flush;
  logic                    busy;

  modport master (
    output src1_addr, src1_en, src2_addr, src2_en,
           wb_addr, wb_data, wb_en, rf_rdata, flush,
    input  src1_data, src1_st, src2_data, src2_st,
           wb_ack, rf_addr, rf_wdata, rf_we, rf_re, busy
  );

  modport slave (
    input  src1_addr, src1_en, src2_addr, src2_en,
           wb_addr, wb_data, wb_en, rf_rdata, flush,
    output src1_data, src1_st, src2_data, src2_st,
           wb_ack, rf_addr, rf_wdata, rf_we, rf_re, busy
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Arbitrates two read requesters and the writeback port onto one RF port.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
//
// state   | meaning
// IDLE    | arbitrate: at most one write or read grant per cycle
// RD_WAIT | read in flight; rf_rdata (or bypass data) returned, no grant
module regfile_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int WR_BURST_MAX = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  regfile_port_arbiter_if.slave io_bus
);
  localparam int CW = $clog2(WR_BURST_MAX + 1);

  typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic            r_gnt_port, w_gnt_port_nxt;
  logic            r_gnt_zero, w_gnt_zero_nxt;
  logic [WIDTH-1:0] r_src1_data, r_src2_data;

  logic                    w_rd_pend;
  logic                    w_sel;
  logic [REG_ADDR_LEN-1:0] w_rd_addr;
  logic                    w_wr_ok;
  logic                    w_done;
  logic [WIDTH-1:0]        w_rd_val;

`ifdef RF_BYPASS_EN
  logic             r_byp, w_byp_nxt;
  logic [WIDTH-1:0] r_byp_data, w_byp_data_nxt;
  logic                    w_pref_en;
  logic [REG_ADDR_LEN-1:0] w_pref_addr;

  assign w_pref_en   = r_rr_ptr ? io_bus.src2_en : io_bus.src1_en;
  assign w_pref_addr = r_rr_ptr ? io_bus.src2_addr : io_bus.src1_addr;
  assign w_rd_val    = r_byp ? r_byp_data : (r_gnt_zero ? '0 : io_bus.rf_rdata);
`else
  assign w_rd_val    = r_gnt_zero ? '0 : io_bus.rf_rdata;
`endif

  // w_sel: 0 = src1, 1 = src2; preferred port wins when it is requesting
  assign w_rd_pend = io_bus.src1_en | io_bus.src2_en;
  assign w_sel     = r_rr_ptr ? io_bus.src2_en : ~io_bus.src1_en;
  assign w_rd_addr = w_sel ? io_bus.src2_addr : io_bus.src1_addr;
  assign w_wr_ok   = io_bus.wb_en && ((r_wr_cnt < CW'(WR_BURST_MAX)) || !w_rd_pend);
  assign w_done    = (r_state == ST_RD_WAIT) && !io_bus.flush && !i_rst;

  assign io_bus.src1_st   = w_done && !r_gnt_port;
  assign io_bus.src2_st   = w_done &&  r_gnt_port;
  assign io_bus.src1_data = io_bus.src1_st ? w_rd_val : r_src1_data;
  assign io_bus.src2_data = io_bus.src2_st ? w_rd_val : r_src2_data;
  assign io_bus.busy      = (r_state == ST_RD_WAIT);

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_gnt_port_nxt  = r_gnt_port;
    w_gnt_zero_nxt  = r_gnt_zero;
    io_bus.rf_addr  = '0;
    io_bus.rf_wdata = '0;
    io_bus.rf_we    = 1'b0;
    io_bus.rf_re    = 1'b0;
    io_bus.wb_ack   = 1'b0;
`ifdef RF_BYPASS_EN
    w_byp_nxt      = 1'b0;
    w_byp_data_nxt = r_byp_data;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!io_bus.flush) begin
          if (w_wr_ok) begin
            io_bus.wb_ack   = 1'b1;
            io_bus.rf_we    = |io_bus.wb_addr;
            io_bus.rf_addr  = io_bus.wb_addr;
            io_bus.rf_wdata = io_bus.wb_data;
            w_wr_cnt_nxt    = w_rd_pend ? r_wr_cnt + CW'(1) : '0;
`ifdef RF_BYPASS_EN
            if (w_pref_en && (w_pref_addr == io_bus.wb_addr) && |io_bus.wb_addr) begin
              w_byp_nxt      = 1'b1;
              w_byp_data_nxt = io_bus.wb_data;
              w_gnt_port_nxt = r_rr_ptr;
              w_gnt_zero_nxt = 1'b0;
              w_state_nxt    = ST_RD_WAIT;
            end
`endif
          end else if (w_rd_pend) begin
            io_bus.rf_re   = 1'b1;
            io_bus.rf_addr = w_rd_addr;
            w_gnt_port_nxt = w_sel;
            w_gnt_zero_nxt = ~|w_rd_addr;
            w_wr_cnt_nxt   = '0;
            w_state_nxt    = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        w_state_nxt = ST_IDLE;
        // round-robin advances only on a delivered read, so a flushed read keeps priority
        if (w_done) w_rr_ptr_nxt = ~r_gnt_port;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_wr_cnt    <= '0;
      r_gnt_port  <= 1'b0;
      r_gnt_zero  <= 1'b0;
      r_src1_data <= '0;
      r_src2_data <= '0;
`ifdef RF_BYPASS_EN
      r_byp       <= 1'b0;
      r_byp_data  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_gnt_port <= w_gnt_port_nxt;
      r_gnt_zero <= w_gnt_zero_nxt;
      if (io_bus.src1_st) r_src1_data <= w_rd_val;
      if (io_bus.src2_st) r_src2_data <= w_rd_val;
`ifdef RF_BYPASS_EN
      r_byp      <= w_byp_nxt;
      r_byp_data <= w_byp_data_nxt;
`endif
    end
  end
endmodule
